vga_ram_arbiter: RTL and testbench
==================================

VGA_RAM_ARBITER -- requirements
Module: vga_ram_arbiter

Interface
REQ-001 SHALL have parameter DISP_ADDR_1, default 32'h0000_0100: word address of the first display word, driving ram_data_1.
REQ-002 SHALL have parameter DISP_ADDR_2, default 32'h0000_0104: word address of the second display word, driving ram_data_2.
REQ-003 SHALL use one clock and a synchronous, active-high reset.
REQ-004 SHALL have port vga_clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: synchronous active-high reset.
REQ-006 SHALL have port frame_start, input, 1 bit: one-cycle pulse at vertical-blank start.
REQ-007 SHALL have port cpu_req, input, 1 bit: CPU read request; held high until cpu_ack.
REQ-008 SHALL have port cpu_addr, input, 32 bits: CPU read address; stable while cpu_req is high.
REQ-009 SHALL have port cpu_ack, output, 1 bit: one-cycle pulse; cpu_rdata is valid in that cycle.
REQ-010 SHALL have port cpu_rdata, output, 32 bits: CPU read data, held until the next ack.
REQ-011 SHALL have port ram_en, output, 1 bit: RAM read enable (registered).
REQ-012 SHALL have port ram_addr, output, 32 bits: RAM read address (registered).
REQ-013 SHALL have port ram_rdata, input, 32 bits: RAM data, valid the cycle after a cycle with ram_en=1.
REQ-014 SHALL have port ram_data_1, output, 32 bits: display snapshot word 1, fed to the pixel driver.
REQ-015 SHALL have port ram_data_2, output, 32 bits: display snapshot word 2.
REQ-016 SHALL have port snap_done, output, 1 bit: one-cycle pulse when both snapshot words update.
REQ-017 SHALL have port overrun_cnt, output, 8 bits: saturating count of dropped frame_start pulses.

Function
REQ-018 SHALL implement FSM states IDLE, CPU_ISS, CPU_CAP, D1_ISS, D2_ISS, D_CAP.
REQ-019 SHALL set disp_pend on any frame_start and clear it when IDLE accepts a display fetch.
REQ-020 SHALL, in IDLE with (disp_pend or frame_start), set ram_en=1 and ram_addr=DISP_ADDR_1, then go to D1_ISS; display fetch has priority over cpu_req.
REQ-021 SHALL, in D1_ISS, set ram_en=1 and ram_addr=DISP_ADDR_2, then go to D2_ISS.
REQ-022 SHALL, in D2_ISS, capture ram_rdata into an internal shadow register, set ram_en=0, then go to D_CAP.
REQ-023 SHALL, in D_CAP, load ram_data_2<=ram_rdata and ram_data_1<=shadow in the same edge, pulse snap_done, then go to IDLE; ram_data_1/2 never change at any other time.
REQ-024 SHALL, in IDLE with no display work, cpu_req=1 and cpu_ack=0, set ram_en=1 and ram_addr=cpu_addr, then go to CPU_ISS.
REQ-025 SHALL, in CPU_ISS, set ram_en=0 and go to CPU_CAP.
REQ-026 SHALL, in CPU_CAP, load cpu_rdata<=ram_rdata, pulse cpu_ack, then go to IDLE.
REQ-027 SHALL make CPU latency fixed: cpu_ack rises 3 edges after the accepting edge; display snap_done rises 4 edges after acceptance.
REQ-028 SHALL never abort an in-flight transaction: a frame_start during CPU_ISS/CPU_CAP only sets disp_pend, and display runs next from IDLE.
REQ-029 SHALL increment overrun_cnt, saturating at 255, when frame_start arrives while disp_pend=1 or the state is D1_ISS/D2_ISS/D_CAP; that pulse is dropped, so at most one fetch is outstanding.
REQ-030 SHALL, when frame_start and cpu_req occur together in IDLE, serve display first, then CPU; the CPU waits a further 4 cycles.
REQ-031 SHALL drive ram_en=0 in IDLE when no request is accepted; ram_addr holds its last value.

Reset
REQ-032 SHALL, on rst=1 at a clock edge, force state=IDLE, disp_pend=0, and all outputs to 0 (ram_en, ram_addr, cpu_ack, cpu_rdata, ram_data_1, ram_data_2, snap_done, overrun_cnt).
REQ-033 SHALL discard a transaction in flight when reset is applied: no cpu_ack and no snap_done follow it.

Verification
REQ-034 SHALL cover CPU read: RAM model with 1-cycle latency, cpu_addr=0x20 holding 0xDEADBEEF -> ram_en high for 1 cycle with ram_addr=0x20, cpu_ack on the 3rd edge, cpu_rdata=0xDEADBEEF.
REQ-035 SHALL cover snapshot: [0x100]=0x5A5, [0x104]=0x3, frame_start pulse -> ram_addr 0x100 then 0x104 on consecutive cycles, snap_done on the 4th edge, ram_data_1=0x5A5 and ram_data_2=0x3 updated in the same cycle.
REQ-036 SHALL cover collision: frame_start and cpu_req in the same IDLE cycle -> snapshot completes first, cpu_ack 4 cycles later than the uncontended case.
REQ-037 SHALL cover overrun: a frame_start during D2_ISS, plus 300 such events -> no extra fetch, overrun_cnt saturates at 255.
REQ-038 SHALL cover reset mid-operation: rst in CPU_CAP -> no cpu_ack, all outputs 0, the next cpu_req is served normally.

Source files
------------

// File: rtl/vga_ram_arbiter.sv
// Arbiter for a single-port read RAM: snapshots two display words per frame and serves CPU reads otherwise.
// Latency: cpu_ack on the 3rd edge counting the accepting edge, snap_done on the 4th; display wins ties.
// Backpressure: cpu_req is held until cpu_ack; frame_start pulses arriving while a fetch is outstanding are dropped and counted.
module vga_ram_arbiter #(
    parameter logic [31:0] DISP_ADDR_1 = 32'h0000_0100,
    parameter logic [31:0] DISP_ADDR_2 = 32'h0000_0104
) (
    input  logic        vga_clk,
    input  logic        rst,
    input  logic        frame_start,
    input  logic        cpu_req,
    input  logic [31:0] cpu_addr,
    output logic        cpu_ack,
    output logic [31:0] cpu_rdata,
    output logic        ram_en,
    output logic [31:0] ram_addr,
    input  logic [31:0] ram_rdata,
    output logic [31:0] ram_data_1,
    output logic [31:0] ram_data_2,
    output logic        snap_done,
    output logic [7:0]  overrun_cnt
);

    typedef enum logic [2:0] {
        IDLE, CPU_ISS, CPU_CAP, D1_ISS, D2_ISS, D_CAP
    } state_t;

    state_t      state, state_nxt;
    logic        disp_pend, disp_pend_nxt;
    logic [31:0] shadow, shadow_nxt;
    logic        ram_en_nxt;
    logic [31:0] ram_addr_nxt;
    logic        cpu_ack_nxt;
    logic [31:0] cpu_rdata_nxt;
    logic [31:0] ram_data_1_nxt, ram_data_2_nxt;
    logic        snap_done_nxt;
    logic [7:0]  overrun_nxt;
    logic        disp_busy;
    logic        fs_drop;

    assign disp_busy = (state == D1_ISS) || (state == D2_ISS) || (state == D_CAP);
    assign fs_drop   = frame_start && (disp_pend || disp_busy);

    always_comb begin
        state_nxt      = state;
        disp_pend_nxt  = disp_pend;
        shadow_nxt     = shadow;
        ram_en_nxt     = 1'b0;
        ram_addr_nxt   = ram_addr;
        cpu_ack_nxt    = 1'b0;
        cpu_rdata_nxt  = cpu_rdata;
        ram_data_1_nxt = ram_data_1;
        ram_data_2_nxt = ram_data_2;
        snap_done_nxt  = 1'b0;
        overrun_nxt    = overrun_cnt;

        // A pulse during an active display fetch is dropped, never queued behind it.
        if (frame_start && !disp_busy)
            disp_pend_nxt = 1'b1;
        if (fs_drop && (overrun_cnt != 8'hFF))
            overrun_nxt = overrun_cnt + 8'd1;

        case (state)
            IDLE: begin
                if (disp_pend || frame_start) begin
                    ram_en_nxt    = 1'b1;
                    ram_addr_nxt  = DISP_ADDR_1;
                    disp_pend_nxt = 1'b0;
                    state_nxt     = D1_ISS;
                end else if (cpu_req && !cpu_ack) begin
                    // cpu_ack gate keeps a still-high cpu_req from being served twice.
                    ram_en_nxt   = 1'b1;
                    ram_addr_nxt = cpu_addr;
                    state_nxt    = CPU_ISS;
                end
            end
            CPU_ISS: begin
                state_nxt = CPU_CAP;
            end
            CPU_CAP: begin
                cpu_rdata_nxt = ram_rdata;
                cpu_ack_nxt   = 1'b1;
                state_nxt     = IDLE;
            end
            D1_ISS: begin
                ram_en_nxt   = 1'b1;
                ram_addr_nxt = DISP_ADDR_2;
                state_nxt    = D2_ISS;
            end
            D2_ISS: begin
                shadow_nxt = ram_rdata;
                state_nxt  = D_CAP;
            end
            D_CAP: begin
                // Both words move on the same edge so the pixel driver never sees a torn pair.
                ram_data_1_nxt = shadow;
                ram_data_2_nxt = ram_rdata;
                snap_done_nxt  = 1'b1;
                state_nxt      = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge vga_clk) begin
        if (rst) begin
            state       <= IDLE;
            disp_pend   <= 1'b0;
            shadow      <= 32'd0;
            ram_en      <= 1'b0;
            ram_addr    <= 32'd0;
            cpu_ack     <= 1'b0;
            cpu_rdata   <= 32'd0;
            ram_data_1  <= 32'd0;
            ram_data_2  <= 32'd0;
            snap_done   <= 1'b0;
            overrun_cnt <= 8'd0;
        end else begin
            state       <= state_nxt;
            disp_pend   <= disp_pend_nxt;
            shadow      <= shadow_nxt;
            ram_en      <= ram_en_nxt;
            ram_addr    <= ram_addr_nxt;
            cpu_ack     <= cpu_ack_nxt;
            cpu_rdata   <= cpu_rdata_nxt;
            ram_data_1  <= ram_data_1_nxt;
            ram_data_2  <= ram_data_2_nxt;
            snap_done   <= snap_done_nxt;
            overrun_cnt <= overrun_nxt;
        end
    end

endmodule

// File: tb/tb_vga_ram_arbiter.sv
// Bench for vga_ram_arbiter: directed latency/boundary scenarios plus a randomized run
// scored at transaction level (per-request data, per-frame accounting, RAM bandwidth).
module tb_vga_ram_arbiter;

    logic        vga_clk = 1'b0;
    logic        rst = 1'b1;
    logic        frame_start = 1'b0;
    logic        cpu_req = 1'b0;
    logic [31:0] cpu_addr = 32'd0;
    logic        cpu_ack;
    logic [31:0] cpu_rdata;
    logic        ram_en;
    logic [31:0] ram_addr;
    logic [31:0] ram_rdata = 32'd0;
    logic [31:0] ram_data_1;
    logic [31:0] ram_data_2;
    logic        snap_done;
    logic [7:0]  overrun_cnt;

    logic [31:0] mem [0:511];
    int total = 0;
    int bad = 0;

    vga_ram_arbiter dut (
        .vga_clk     (vga_clk),
        .rst         (rst),
        .frame_start (frame_start),
        .cpu_req     (cpu_req),
        .cpu_addr    (cpu_addr),
        .cpu_ack     (cpu_ack),
        .cpu_rdata   (cpu_rdata),
        .ram_en      (ram_en),
        .ram_addr    (ram_addr),
        .ram_rdata   (ram_rdata),
        .ram_data_1  (ram_data_1),
        .ram_data_2  (ram_data_2),
        .snap_done   (snap_done),
        .overrun_cnt (overrun_cnt)
    );

    always #5 vga_clk = ~vga_clk;

    // RAM with one cycle of read latency.
    always @(posedge vga_clk) begin
        if (ram_en === 1'b1)
            ram_rdata <= mem[ram_addr[8:0]];
    end

    // Called at posedge+1; returns edges counted from the accepting edge (1) to the ack edge.
    task automatic cpu_read(input logic [31:0] a, output int edges, output logic [31:0] d,
                            output int en_cyc, output logic [31:0] first_addr, output logic ok);
        cpu_addr = a;
        cpu_req = 1'b1;
        edges = 0;
        en_cyc = 0;
        first_addr = 32'hFFFF_FFFF;
        do begin
            @(posedge vga_clk); #1;
            edges++;
            if (edges == 1) first_addr = ram_addr;
            if (ram_en === 1'b1) en_cyc++;
        end while (cpu_ack !== 1'b1 && edges < 50);
        ok = (cpu_ack === 1'b1);
        d = cpu_rdata;
        cpu_req = 1'b0;
        @(posedge vga_clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge vga_clk);
        #1;
        total++;
        if ({ram_en, ram_addr, cpu_ack, cpu_rdata, ram_data_1, ram_data_2, snap_done, overrun_cnt} !== '0) begin
            bad++;
            $display("FAIL reset_outputs en=%0h addr=%0h ack=%0h rdata=%0h d1=%0h d2=%0h snap=%0h ovr=%0d exp all 0",
                     ram_en, ram_addr, cpu_ack, cpu_rdata, ram_data_1, ram_data_2, snap_done, overrun_cnt);
        end
        rst = 1'b0;
    endtask

    task automatic test_cpu_read();
        int edges, en_cyc;
        logic [31:0] d, fa, a;
        logic ok;
        mem[9'h020] = 32'hDEAD_BEEF;
        cpu_read(32'h20, edges, d, en_cyc, fa, ok);
        total++;
        if (!ok || edges != 3) begin bad++; $display("FAIL cpu_latency got=%0d ok=%0b exp=3", edges, ok); end
        total++;
        if (d !== 32'hDEAD_BEEF) begin bad++; $display("FAIL cpu_rdata got=%h exp=deadbeef", d); end
        total++;
        if (en_cyc != 1 || fa !== 32'h20) begin bad++; $display("FAIL cpu_ram_cmd en_cycles=%0d addr=%h exp 1 cycle at 20", en_cyc, fa); end
        for (int i = 0; i < 4; i++) begin
            a = 32'($urandom_range(0, 255));
            cpu_read(a, edges, d, en_cyc, fa, ok);
            total++;
            if (!ok || edges != 3 || d !== mem[a[8:0]] || fa !== a) begin
                bad++;
                $display("FAIL cpu_rand_read addr=%h got lat=%0d data=%h exp lat=3 data=%h", a, edges, d, mem[a[8:0]]);
            end
        end
    endtask

    task automatic test_snapshot();
        mem[9'h100] = 32'h5A5;
        mem[9'h104] = 32'h3;
        frame_start = 1'b1;
        @(posedge vga_clk); #1;
        frame_start = 1'b0;
        total++;
        if (ram_en !== 1'b1 || ram_addr !== 32'h100) begin bad++; $display("FAIL snap_issue1 en=%0b addr=%h exp 1/100", ram_en, ram_addr); end
        @(posedge vga_clk); #1;
        total++;
        if (ram_en !== 1'b1 || ram_addr !== 32'h104) begin bad++; $display("FAIL snap_issue2 en=%0b addr=%h exp 1/104", ram_en, ram_addr); end
        @(posedge vga_clk); #1;
        total++;
        if (ram_en !== 1'b0 || snap_done !== 1'b0 || ram_data_1 !== 32'h0 || ram_data_2 !== 32'h0) begin
            bad++;
            $display("FAIL snap_early en=%0b snap=%0b d1=%h d2=%h exp 0/0/0/0", ram_en, snap_done, ram_data_1, ram_data_2);
        end
        @(posedge vga_clk); #1;
        total++;
        if (snap_done !== 1'b1 || ram_data_1 !== 32'h5A5 || ram_data_2 !== 32'h3) begin
            bad++;
            $display("FAIL snap_update snap=%0b d1=%h d2=%h exp 1/5a5/3", snap_done, ram_data_1, ram_data_2);
        end
        @(posedge vga_clk); #1;
        total++;
        if (snap_done !== 1'b0 || ram_data_1 !== 32'h5A5 || ram_data_2 !== 32'h3) begin
            bad++;
            $display("FAIL snap_hold snap=%0b d1=%h d2=%h exp 0/5a5/3", snap_done, ram_data_1, ram_data_2);
        end
    endtask

    task automatic test_collision();
        int edges = 0;
        int snap_edge = 0;
        logic [31:0] a;
        a = 32'($urandom_range(0, 255));
        cpu_addr = a;
        cpu_req = 1'b1;
        frame_start = 1'b1;
        do begin
            @(posedge vga_clk); #1;
            frame_start = 1'b0;
            edges++;
            if (snap_done === 1'b1 && snap_edge == 0) snap_edge = edges;
        end while (cpu_ack !== 1'b1 && edges < 50);
        total++;
        if (snap_edge != 4) begin bad++; $display("FAIL collide_snap_edge got=%0d exp=4", snap_edge); end
        total++;
        if (cpu_ack !== 1'b1 || edges != 7 || cpu_rdata !== mem[a[8:0]]) begin
            bad++;
            $display("FAIL collide_cpu ack=%0b lat=%0d data=%h exp lat=7 data=%h", cpu_ack, edges, cpu_rdata, mem[a[8:0]]);
        end
        cpu_req = 1'b0;
        @(posedge vga_clk); #1;
    endtask

    task automatic test_overrun();
        int fetches = 0;
        int snaps = 0;
        for (int i = 0; i < 301; i++) begin
            frame_start = 1'b1;
            @(posedge vga_clk); #1;
            frame_start = 1'b0;
            if (ram_en === 1'b1) fetches++;
            @(posedge vga_clk); #1;
            if (ram_en === 1'b1) fetches++;
            frame_start = 1'b1;
            @(posedge vga_clk); #1;
            frame_start = 1'b0;
            if (ram_en === 1'b1) fetches++;
            if (i == 0) begin
                total++;
                if (overrun_cnt !== 8'd1) begin bad++; $display("FAIL overrun_first got=%0d exp=1", overrun_cnt); end
            end
            @(posedge vga_clk); #1;
            if (ram_en === 1'b1) fetches++;
            if (snap_done === 1'b1) snaps++;
        end
        repeat (8) begin
            @(posedge vga_clk); #1;
            if (ram_en === 1'b1) fetches++;
            if (snap_done === 1'b1) snaps++;
        end
        total++;
        if (overrun_cnt !== 8'd255) begin bad++; $display("FAIL overrun_saturate got=%0d exp=255", overrun_cnt); end
        total++;
        if (fetches != 602 || snaps != 301) begin bad++; $display("FAIL overrun_no_extra fetches=%0d snaps=%0d exp 602/301", fetches, snaps); end
    endtask

    task automatic test_reset_mid();
        int acks = 0;
        int edges, en_cyc;
        logic [31:0] d, fa;
        logic ok;
        cpu_addr = 32'h20;
        cpu_req = 1'b1;
        @(posedge vga_clk); #1;
        @(posedge vga_clk); #1;
        rst = 1'b1;
        @(posedge vga_clk); #1;
        total++;
        if ({ram_en, ram_addr, cpu_ack, cpu_rdata, ram_data_1, ram_data_2, snap_done, overrun_cnt} !== '0) begin
            bad++;
            $display("FAIL midreset_outputs en=%0h addr=%0h ack=%0h rdata=%0h d1=%0h d2=%0h snap=%0h ovr=%0d exp all 0",
                     ram_en, ram_addr, cpu_ack, cpu_rdata, ram_data_1, ram_data_2, snap_done, overrun_cnt);
        end
        rst = 1'b0;
        cpu_req = 1'b0;
        repeat (6) begin
            @(posedge vga_clk); #1;
            if (cpu_ack === 1'b1 || snap_done === 1'b1) acks++;
        end
        total++;
        if (acks != 0) begin bad++; $display("FAIL midreset_no_ack got=%0d exp=0", acks); end
        cpu_read(32'h20, edges, d, en_cyc, fa, ok);
        total++;
        if (!ok || edges != 3 || d !== 32'hDEAD_BEEF) begin
            bad++;
            $display("FAIL midreset_next_read lat=%0d data=%h exp 3/deadbeef", edges, d);
        end
    endtask

    task automatic test_random();
        int frames = 0, snaps = 0, acks = 0, en_cyc = 0, wait_cyc = 0;
        int ov0;
        logic prev_ack = 1'b0;
        logic [31:0] p1, p2;
        ov0 = int'(overrun_cnt);
        p1 = ram_data_1;
        p2 = ram_data_2;
        for (int c = 0; c < 600; c++) begin
            frame_start = (c < 560) && ($urandom_range(0, 7) == 0);
            if (frame_start) frames++;
            if (!cpu_req && c < 560 && $urandom_range(0, 2) == 0) begin
                cpu_addr = 32'($urandom_range(0, 511));
                cpu_req = 1'b1;
                wait_cyc = 0;
            end
            @(posedge vga_clk); #1;
            if (ram_en === 1'b1) en_cyc++;
            if (snap_done === 1'b1) begin
                snaps++;
                total++;
                if (ram_data_1 !== mem[9'h100] || ram_data_2 !== mem[9'h104]) begin
                    bad++;
                    $display("FAIL rand_snap d1=%h d2=%h exp %h/%h", ram_data_1, ram_data_2, mem[9'h100], mem[9'h104]);
                end
            end else if (ram_data_1 !== p1 || ram_data_2 !== p2) begin
                total++;
                bad++;
                $display("FAIL rand_display_glitch d1=%h d2=%h exp %h/%h", ram_data_1, ram_data_2, p1, p2);
            end
            p1 = ram_data_1;
            p2 = ram_data_2;
            if (cpu_ack === 1'b1) begin
                acks++;
                total++;
                if (prev_ack || cpu_rdata !== mem[cpu_addr[8:0]]) begin
                    bad++;
                    $display("FAIL rand_cpu addr=%h data=%h prev_ack=%0b exp data=%h single pulse", cpu_addr, cpu_rdata, prev_ack, mem[cpu_addr[8:0]]);
                end
                cpu_req = 1'b0;
            end else if (cpu_req) begin
                wait_cyc++;
                if (wait_cyc > 40) begin
                    total++;
                    bad++;
                    $display("FAIL rand_cpu_timeout addr=%h waited=%0d exp ack within 40", cpu_addr, wait_cyc);
                    cpu_req = 1'b0;
                end
            end
            prev_ack = cpu_ack;
        end
        total++;
        if (frames != snaps + (int'(overrun_cnt) - ov0)) begin
            bad++;
            $display("FAIL rand_frame_account frames=%0d snaps=%0d overruns=%0d exp frames=snaps+overruns", frames, snaps, int'(overrun_cnt) - ov0);
        end
        total++;
        if (en_cyc != 2 * snaps + acks) begin
            bad++;
            $display("FAIL rand_ram_bandwidth en_cycles=%0d exp=%0d", en_cyc, 2 * snaps + acks);
        end
    endtask

    initial begin
        for (int i = 0; i < 512; i++) mem[i] = $urandom;
        test_reset();
        test_cpu_read();
        test_snapshot();
        test_collision();
        test_overrun();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
